sync_down_divider: RTL and testbench

// - Synchronous, loadable modulo-N down-counter and clock-enable divider; counterpart to the team's ripple up-counter.
// - Counts from N-1 down to 0, reloads, and emits a one-cycle terminal-count pulse (tc) once per N enabled cycles.
// - Also emits a registered, glitch-free divided output (div_out) for downstream clock-enable use.
// - Sits beside the ripple counters in the counters/dividers library; all state is clocked by the single system clock.
//

---
 rtl/counter_pkg.sv | 12 +
 rtl/down_count_core.sv | 72 +++++++
 rtl/sync_down_divider.sv | 57 +++++
 tb/tb_sync_down_divider.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counters/dividers library.
package counter_pkg;

    localparam int unsigned CNT_WIDTH       = 8;
    localparam int unsigned CNT_DEFAULT_DIV = 6;

    // Threshold at or above which div_out is high: floor(period / 2).
    function automatic int unsigned half(input int unsigned period);
        return period >> 1;
    endfunction

endpackage

// File: rtl/down_count_core.sv
// Period and count registers with load/reload priority for the modulo-N down-counter.
module down_count_core
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = CNT_WIDTH,
    parameter int unsigned DEFAULT_DIV = CNT_DEFAULT_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_count_next,
    output logic [WIDTH-1:0] o_period_next,
    output logic             o_reload,
    output logic             o_load_err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_count;
    logic             r_load_err;

    logic [WIDTH-1:0] w_period_next;
    logic [WIDTH-1:0] w_count_next;
    logic             w_reload;
    logic             w_load_err;

    // Load always beats counting; a zero load is rejected and freezes the count for that edge.
    always_comb begin
        w_period_next = r_period;
        w_count_next  = r_count;
        w_reload      = 1'b0;
        w_load_err    = 1'b0;
        if (i_load) begin
            if (i_load_val != '0) begin
                w_period_next = i_load_val;
                w_count_next  = i_load_val - ONE;
            end else begin
                w_load_err = 1'b1;
            end
        end else if (i_en) begin
            if (r_count == '0) begin
                w_count_next = r_period - ONE;
                w_reload     = 1'b1;
            end else begin
                w_count_next = r_count - ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_period   <= WIDTH'(DEFAULT_DIV);
            r_count    <= WIDTH'(DEFAULT_DIV - 1);
            r_load_err <= 1'b0;
        end else begin
            r_period   <= w_period_next;
            r_count    <= w_count_next;
            r_load_err <= w_load_err;
        end
    end

    assign o_count       = r_count;
    assign o_count_next  = w_count_next;
    assign o_period_next = w_period_next;
    assign o_reload      = w_reload;
    assign o_load_err    = r_load_err;

endmodule

// File: rtl/sync_down_divider.sv
// Loadable modulo-N down-counter with registered terminal-count pulse and divided output.
module sync_down_divider
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = CNT_WIDTH,
    parameter int unsigned DEFAULT_DIV = CNT_DEFAULT_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_div_out,
    output logic             o_load_err
);

    localparam logic DIV_RST = ((DEFAULT_DIV - 1) >= half(DEFAULT_DIV));

    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_period_next;
    logic             w_reload;
    logic             r_tc;
    logic             r_div_out;

    down_count_core #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (i_en),
        .i_load        (i_load),
        .i_load_val    (i_load_val),
        .o_count       (o_count),
        .o_count_next  (w_count_next),
        .o_period_next (w_period_next),
        .o_reload      (w_reload),
        .o_load_err    (o_load_err)
    );

    // div_out tracks the post-edge count/period so it stays aligned with o_count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tc      <= 1'b0;
            r_div_out <= DIV_RST;
        end else begin
            r_tc      <= w_reload;
            r_div_out <= (32'(w_count_next) >= half(32'(w_period_next)));
        end
    end

    assign o_tc      = r_tc;
    assign o_div_out = r_div_out;

endmodule

// File: tb/tb_sync_down_divider.sv
// Self-checking bench: per-cycle model comparison plus directed literal expectations.
module tb_sync_down_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc;
    logic       div_out;
    logic       load_err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    // Model state: period, count, and the pulses expected after the last edge.
    int mp, mc, mtc, merr;

    sync_down_divider #(
        .WIDTH       (8),
        .DEFAULT_DIV (6)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_load     (load),
        .i_load_val (load_val),
        .o_count    (count),
        .o_tc       (tc),
        .o_div_out  (div_out),
        .o_load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            mp <= 6; mc <= 5; mtc <= 0; merr <= 0;
        end else if (load && load_val != 0) begin
            mp <= int'(load_val); mc <= int'(load_val) - 1; mtc <= 0; merr <= 0;
        end else if (load) begin
            mtc <= 0; merr <= 1;
        end else if (en) begin
            merr <= 0;
            mtc  <= (mc == 0) ? 1 : 0;
            mc   <= (mc == 0) ? mp - 1 : mc - 1;
        end else begin
            mtc <= 0; merr <= 0;
        end
    end

    // div_out must always equal (count >= floor(period/2)) for the current state.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_count", int'(count), mc);
            chk("model_tc", int'(tc), mtc);
            chk("model_div_out", int'(div_out), (mc >= mp / 2) ? 1 : 0);
            chk("model_load_err", int'(load_err), merr);
        end
    end

    task automatic step(input bit r, input bit e, input bit l, input int v);
        rst_n    = r;
        en       = e;
        load     = l;
        load_val = v[7:0];
        @(negedge clk);
    endtask

    int exp_cnt[13] = '{4, 3, 2, 1, 0, 5, 4, 3, 2, 1, 0, 5, 4};
    int exp_div[13] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};

    initial begin
        rst_n = 1'b0; en = 1'b1; load = 1'b0; load_val = 8'd0;

        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk_on = 1'b1;
        chk("rst_count", int'(count), 5);
        chk("rst_tc", int'(tc), 0);
        chk("rst_div_out", int'(div_out), 1);
        chk("rst_load_err", int'(load_err), 0);

        for (int i = 0; i < 13; i++) begin
            step(1, 1, 0, 0);
            chk("free_count", int'(count), exp_cnt[i]);
            chk("free_tc", int'(tc), (i == 5 || i == 11) ? 1 : 0);
            chk("free_div_out", int'(div_out), exp_div[i]);
        end

        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("pre_load_count", int'(count), 2);
        step(1, 1, 1, 3);
        chk("load3_count", int'(count), 2);
        chk("load3_tc", int'(tc), 0);
        step(1, 1, 0, 0);
        chk("n3_count_a", int'(count), 1);
        step(1, 1, 0, 0);
        chk("n3_count_b", int'(count), 0);
        chk("n3_div_b", int'(div_out), 0);
        step(1, 1, 0, 0);
        chk("n3_reload_count", int'(count), 2);
        chk("n3_reload_tc", int'(tc), 1);

        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("at_zero_count", int'(count), 0);
        step(1, 1, 1, 4);
        chk("load_tc_coinc_count", int'(count), 3);
        chk("load_tc_coinc_tc", int'(tc), 0);

        step(1, 1, 1, 5);
        chk("load5_count", int'(count), 4);
        step(1, 1, 1, 0);
        chk("zero_load_err", int'(load_err), 1);
        chk("zero_load_count", int'(count), 4);
        chk("zero_load_tc", int'(tc), 0);
        step(1, 1, 0, 0);
        chk("after_err_count", int'(count), 3);
        chk("after_err_flag", int'(load_err), 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("n5_reload_count", int'(count), 4);
        chk("n5_reload_tc", int'(tc), 1);

        step(1, 1, 0, 0);
        chk("gate_en1_count", int'(count), 3);
        step(1, 0, 0, 0);
        chk("gate_en0_count", int'(count), 3);
        chk("gate_en0_tc", int'(tc), 0);
        step(1, 1, 0, 0);
        chk("gate_en1b_count", int'(count), 2);

        step(1, 0, 1, 1);
        chk("n1_load_count", int'(count), 0);
        chk("n1_load_tc", int'(tc), 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            chk("n1_count", int'(count), 0);
            chk("n1_tc", int'(tc), 1);
            chk("n1_div_out", int'(div_out), 1);
        end

        step(1, 1, 1, 9);
        step(1, 1, 0, 0);
        chk("n9_count", int'(count), 7);
        step(0, 1, 1, 3);
        step(0, 1, 1, 3);
        chk("midrst_count", int'(count), 5);
        chk("midrst_tc", int'(tc), 0);
        chk("midrst_div_out", int'(div_out), 1);
        chk("midrst_load_err", int'(load_err), 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
        chk("midrst_reload_count", int'(count), 5);
        chk("midrst_reload_tc", int'(tc), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
